// File: rtl/wide_add_sequencer.sv
// Multi-cycle (16*WORDS)-bit add/subtract built around a single 16-bit adder.
// Operands are taken LSB chunk first, with the carry held in a register between chunks.
module wide_add_sequencer #(
   parameter int WORDS = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start_valid,
   output logic                o_start_ready,
   input  logic [16*WORDS-1:0] i_a,
   input  logic [16*WORDS-1:0] i_b,
   input  logic                i_sub,
   input  logic                i_carry_in,
   output logic                o_result_valid,
   input  logic                i_result_ready,
   output logic [16*WORDS-1:0] o_result,
   output logic                o_carry_out,
   output logic                o_overflow
);

   localparam int W  = 16 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_idx;
   logic [W-1:0]    r_op_a;
   logic [W-1:0]    r_op_b;
   logic [W-1:0]    r_result;
   logic            r_carry;
   logic            r_carry_out;
   logic            r_overflow;
   logic            r_start_ready;
   logic            r_result_valid;

   logic [15:0]     w_in1;
   logic [15:0]     w_in2;
   logic [15:0]     w_sum;
   logic            w_cout;
   logic            w_last;

   assign w_in1  = r_op_a[int'(r_idx)*16 +: 16];
   assign w_in2  = r_op_b[int'(r_idx)*16 +: 16];
   assign w_last = (r_idx == IW'(WORDS - 1));

   // The one and only adder: 16-bit chunk sum with carry in and carry out.
   assign {w_cout, w_sum} = {1'b0, w_in1} + {1'b0, w_in2} + {16'd0, r_carry};

   assign o_start_ready  = r_start_ready;
   assign o_result_valid = r_result_valid;
   assign o_result       = r_result;
   assign o_carry_out    = r_carry_out;
   assign o_overflow     = r_overflow;

   // Sequencer FSM: accept in IDLE, walk chunks in RUN, hold result in DONE.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= S_IDLE;
         r_idx          <= '0;
         r_op_a         <= '0;
         r_op_b         <= '0;
         r_result       <= '0;
         r_carry        <= 1'b0;
         r_carry_out    <= 1'b0;
         r_overflow     <= 1'b0;
         r_start_ready  <= 1'b1;
         r_result_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start_valid && r_start_ready) begin
                  // Subtract is A + ~B + 1, so the carry register supplies the +1.
                  r_op_a        <= i_a;
                  r_op_b        <= i_sub ? ~i_b : i_b;
                  r_carry       <= i_sub ? 1'b1 : i_carry_in;
                  r_idx         <= '0;
                  r_start_ready <= 1'b0;
                  r_state       <= S_RUN;
               end else begin
                  r_start_ready <= 1'b1;
               end
            end
            S_RUN: begin
               r_result[int'(r_idx)*16 +: 16] <= w_sum;
               r_carry                        <= w_cout;
               r_idx                          <= r_idx + IW'(1);
               if (w_last) begin
                  r_carry_out    <= w_cout;
                  r_overflow     <= (r_op_a[W-1] == r_op_b[W-1]) && (w_sum[15] != r_op_a[W-1]);
                  r_result_valid <= 1'b1;
                  r_state        <= S_DONE;
               end else begin
                  r_result_valid <= 1'b0;
               end
            end
            S_DONE: begin
               if (i_result_ready) begin
                  r_result_valid <= 1'b0;
                  r_start_ready  <= 1'b1;
                  r_state        <= S_IDLE;
               end else begin
                  r_result_valid <= 1'b1;
               end
            end
            default: begin
               r_state        <= S_IDLE;
               r_idx          <= '0;
               r_start_ready  <= 1'b1;
               r_result_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (WORDS=4): vector table plus
// hand-written backpressure and mid-operation reset sequences.
module tb_wide_add_sequencer;

   localparam int WORDS = 4;
   localparam int W     = 64;

   logic          clk;
   logic          rst;
   logic          start_valid;
   logic          start_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          sub;
   logic          carry_in;
   logic          result_valid;
   logic          result_ready;
   logic [W-1:0]  result;
   logic          carry_out;
   logic          overflow;

   int n_pass;
   int n_total;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic         cin;
      logic [W-1:0] exp_result;
      logic         exp_cout;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs [8];

   wide_add_sequencer #(.WORDS(WORDS)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_start_valid  (start_valid),
      .o_start_ready  (start_ready),
      .i_a            (a),
      .i_b            (b),
      .i_sub          (sub),
      .i_carry_in     (carry_in),
      .o_result_valid (result_valid),
      .i_result_ready (result_ready),
      .o_result       (result),
      .o_carry_out    (carry_out),
      .o_overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Waits up to 20 edges for result_valid; returns edges counted after the accept edge.
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (cyc < 20) begin
         @(posedge clk);
         cyc++;
         #1;
         if (result_valid) break;
      end
   endtask

   task automatic run_op(input string name, input vec_t v);
      int cyc;
      @(negedge clk);
      a           = v.a;
      b           = v.b;
      sub         = v.sub;
      carry_in    = v.cin;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      a           = {$urandom, $urandom};
      b           = {$urandom, $urandom};
      sub         = 1'($urandom);
      carry_in    = 1'($urandom);
      wait_valid(cyc);
      chk({name, " latency"}, 64'(cyc), 64'd4);
      chk({name, " result"}, result, v.exp_result);
      chk({name, " carry_out"}, {63'd0, carry_out}, {63'd0, v.exp_cout});
      chk({name, " overflow"}, {63'd0, overflow}, {63'd0, v.exp_ovf});
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      result_ready = 1'b0;
      chk({name, " idle start_ready"}, {63'd0, start_ready}, 64'd1);
      chk({name, " idle result_valid"}, {63'd0, result_valid}, 64'd0);
   endtask

   initial begin
      int cyc;
      logic [W-1:0] held;
      n_pass = 0;
      n_total = 0;

      vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
      vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[3] = '{64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[6] = '{64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
      vecs[7] = '{64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};

      rst = 1'b1;
      start_valid = 1'b0;
      result_ready = 1'b0;
      a = '0;
      b = '0;
      sub = 1'b0;
      carry_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset start_ready", {63'd0, start_ready}, 64'd1);
      chk("reset result_valid", {63'd0, result_valid}, 64'd0);
      chk("reset result", result, 64'd0);
      chk("reset carry_out", {63'd0, carry_out}, 64'd0);
      chk("reset overflow", {63'd0, overflow}, 64'd0);

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i]);
      end

      // Backpressure: hold result in DONE while a new request is offered.
      @(negedge clk);
      a = 64'h0000_0000_0000_FFFF;
      b = 64'h1;
      sub = 1'b0;
      carry_in = 1'b0;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      a = 64'd100;
      b = 64'd23;
      wait_valid(cyc);
      chk("bp latency", 64'(cyc), 64'd4);
      held = result;
      chk("bp result", held, 64'h0000_0000_0001_0000);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp hold%0d result", k), result, 64'h0000_0000_0001_0000);
         chk($sformatf("bp hold%0d valid", k), {63'd0, result_valid}, 64'd1);
         chk($sformatf("bp hold%0d start_ready", k), {63'd0, start_ready}, 64'd0);
         chk($sformatf("bp hold%0d flags", k), {62'd0, carry_out, overflow}, 64'd0);
      end
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      result_ready = 1'b0;
      chk("bp handoff start_ready", {63'd0, start_ready}, 64'd1);
      chk("bp handoff valid", {63'd0, result_valid}, 64'd0);
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      chk("bp accept start_ready", {63'd0, start_ready}, 64'd0);
      wait_valid(cyc);
      chk("bp new latency", 64'(cyc), 64'd4);
      chk("bp new result", result, 64'd123);
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      result_ready = 1'b0;

      // Reset during the second RUN cycle discards the operation.
      @(negedge clk);
      a = 64'hFFFF_FFFF_FFFF_FFFF;
      b = 64'h1;
      sub = 1'b0;
      carry_in = 1'b0;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst mid start_ready", {63'd0, start_ready}, 64'd1);
      chk("rst mid valid", {63'd0, result_valid}, 64'd0);
      chk("rst mid result", result, 64'd0);
      cyc = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (result_valid) cyc++;
      end
      chk("rst mid no result", 64'(cyc), 64'd0);
      run_op("post rst 3+4", '{64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
